updown_sequence_decoder: RTL

- Observer for the 2-bit binary up/down counter: samples the counter's {q1,q0} outputs on a qualified strobe, classifies each transition as increment, decrement, hold or illegal jump, and maintains a signed-free wrapping position count.
- Recovers the controller's up input from observed motion (decrement observed => up=1, per the counter's next-state equation).
- Sits downstream of the counter in the FSM demo designs as its monitor/decoder.

---
 rtl/updown_sequence_decoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/updown_sequence_decoder.sv
// Observer for a 2-bit up/down counter: classifies {q1,q0} transitions and tracks position.
// Optional hold-stall detection is built when STALL_TIMEOUT_EN is defined.
module updown_sequence_decoder #(
  parameter int POS_WIDTH     = 8,
  parameter int ERR_CNT_WIDTH = 4,
  parameter int STALL_LIMIT   = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     sample_valid,
  input  logic                     q1,
  input  logic                     q0,
  input  logic                     clear_err,
  output logic                     step_valid,
  output logic                     step_inc,
  output logic                     up_est,
  output logic [POS_WIDTH-1:0]     position,
  output logic                     error,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     stall
);

  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

  localparam logic [POS_WIDTH-1:0]     POS_ONE = POS_WIDTH'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

  state_t                   state_reg;
  logic [1:0]               prev_reg;
  logic                     step_valid_reg;
  logic                     step_inc_reg;
  logic                     up_est_reg;
  logic [POS_WIDTH-1:0]     position_reg;
  logic                     error_reg;
  logic [ERR_CNT_WIDTH-1:0] err_count_reg;

  logic [1:0] cur;
  logic [1:0] delta;

  assign cur   = {q1, q0};
  // Modulo-4 difference: 1 = increment, 3 = decrement, 0 = hold, 2 = impossible jump.
  assign delta = cur - prev_reg;

`ifdef STALL_TIMEOUT_EN
  localparam int STALL_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

  logic [STALL_W-1:0] stall_cnt_reg;
  logic               stall_reg;
  assign stall = stall_reg;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      prev_reg       <= 2'b00;
      step_valid_reg <= 1'b0;
      step_inc_reg   <= 1'b0;
      up_est_reg     <= 1'b1;
      position_reg   <= '0;
      error_reg      <= 1'b0;
      err_count_reg  <= '0;
`ifdef STALL_TIMEOUT_EN
      stall_cnt_reg  <= '0;
      stall_reg      <= 1'b0;
`endif
    end else begin
      step_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sample_valid) begin
            prev_reg  <= cur;
            state_reg <= TRACK;
          end
        end
        TRACK: begin
          if (sample_valid) begin
            prev_reg <= cur;
            case (delta)
              2'd1: begin
                step_valid_reg <= 1'b1;
                step_inc_reg   <= 1'b1;
                up_est_reg     <= 1'b0;
                position_reg   <= position_reg + POS_ONE;
`ifdef STALL_TIMEOUT_EN
                stall_cnt_reg  <= '0;
                stall_reg      <= 1'b0;
`endif
              end
              2'd3: begin
                step_valid_reg <= 1'b1;
                step_inc_reg   <= 1'b0;
                up_est_reg     <= 1'b1;
                position_reg   <= position_reg - POS_ONE;
`ifdef STALL_TIMEOUT_EN
                stall_cnt_reg  <= '0;
                stall_reg      <= 1'b0;
`endif
              end
              2'd0: begin
`ifdef STALL_TIMEOUT_EN
                if (stall_cnt_reg != STALL_MAX)
                  stall_cnt_reg <= stall_cnt_reg + STALL_ONE;
                if (stall_cnt_reg >= STALL_LAST)
                  stall_reg <= 1'b1;
`endif
              end
              default: begin
                state_reg <= ERROR;
                error_reg <= 1'b1;
                if (err_count_reg != '1)
                  err_count_reg <= err_count_reg + ERR_ONE;
`ifdef STALL_TIMEOUT_EN
                stall_cnt_reg <= '0;
                stall_reg     <= 1'b0;
`endif
              end
            endcase
          end
        end
        ERROR: begin
          // Clear takes priority over any sample in the same cycle; that sample is dropped.
          if (clear_err) begin
            state_reg <= IDLE;
            error_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign step_valid = step_valid_reg;
  assign step_inc   = step_inc_reg;
  assign up_est     = up_est_reg;
  assign position   = position_reg;
  assign error      = error_reg;
  assign err_count  = err_count_reg;

endmodule
